// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480 @ 60 Hz timing constants. Pixel-generation blocks import this
// package so that they address the frame with the same numbers as the timing
// generator.
//   - Visible / porch / sync widths for both axes, plus derived totals and the
//     first/last counter value of each sync pulse.
//   - CNT_W : width of the pixel/line counters.
//   - sync_t: bundle of the three registered timing flags.
//   - in_window(): inclusive range test used for the sync windows.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 11;

  // Horizontal timing, in pixel-clock cycles.
  localparam int H_VISIBLE    = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800
  localparam int H_SYNC_START = H_VISIBLE + H_FP;                  // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;         // 751

  // Vertical timing, in lines.
  localparam int V_VISIBLE    = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525
  localparam int V_SYNC_START = V_VISIBLE + V_FP;                  // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;         // 491

  // Sync active level: 0 = active-low (standard for this mode).
  localparam logic SYNC_POL = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Inclusive window test: lo <= value <= hi.
  function automatic logic in_window(input cnt_t value, input cnt_t lo,
                                     input cnt_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// -----------------------------------------------------------------------------
// vga_wrap_counter
// Generic up-counter that wraps to zero after MAX. Any value at or above MAX
// also wraps to zero on the next increment, so an out-of-range state can never
// persist.
// Ports:
//   clk_i   : clock, counts on the rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : advance the count on this edge
//   count_o : registered count
//   next_o  : value count_o takes on the next edge (lets the parent register
//             decoded flags in step with the count)
// -----------------------------------------------------------------------------
module vga_wrap_counter #(
  parameter int W   = 11,
  parameter int MAX = 799
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      if (count_q >= MAX_C) begin
        count_d = '0;
      end else begin
        count_d = count_q + ONE_C;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_controller_640_60.sv
// -----------------------------------------------------------------------------
// vga_controller_640_60
// Free-running VGA timing generator (640x480 @ 60 Hz by default). Produces
// the current pixel column/line and registered sync and blanking flags that
// always describe the counter values presented on the same cycle.
// Ports:
//   pixel_clk : pixel clock, all state updates on its rising edge
//   rst       : asynchronous active-high reset, restarts timing at (0,0)
//   HS        : horizontal sync, active level set by SYNC_POL
//   VS        : vertical sync, active level set by SYNC_POL
//   hcounter  : current pixel column, 0 .. H_TOTAL-1
//   vcounter  : current line, 0 .. V_TOTAL-1
//   blank     : 1 when the current pixel lies outside the visible area
// -----------------------------------------------------------------------------
module vga_controller_640_60 #(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP      = vga_timing_pkg::V_FP,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BP      = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
  input  logic                             pixel_clk,
  input  logic                             rst,
  output logic                             HS,
  output logic                             VS,
  output logic [vga_timing_pkg::CNT_W-1:0] hcounter,
  output logic [vga_timing_pkg::CNT_W-1:0] vcounter,
  output logic                             blank
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_VIS_C   = cnt_t'(H_VISIBLE);
  localparam cnt_t HS_FIRST  = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_LAST   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t V_VIS_C   = cnt_t'(V_VISIBLE);
  localparam cnt_t VS_FIRST  = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_LAST   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  // Flags at reset describe pixel (0,0): syncs idle, pixel visible.
  localparam sync_t SYNC_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank: 1'b0};

  cnt_t  h_count;
  cnt_t  h_next;
  cnt_t  v_count;
  cnt_t  v_next;
  logic  line_wrap;
  sync_t sync_q;
  sync_t sync_d;

  vga_wrap_counter #(
    .W   (CNT_W),
    .MAX (H_TOTAL - 1)
  ) u_hcount (
    .clk_i   (pixel_clk),
    .rst_i   (rst),
    .inc_i   (1'b1),
    .count_o (h_count),
    .next_o  (h_next)
  );

  // The column counter advances every cycle, so its next value is zero only
  // on the edge where the line wraps.
  assign line_wrap = (h_next == '0);

  vga_wrap_counter #(
    .W   (CNT_W),
    .MAX (V_TOTAL - 1)
  ) u_vcount (
    .clk_i   (pixel_clk),
    .rst_i   (rst),
    .inc_i   (line_wrap),
    .count_o (v_count),
    .next_o  (v_next)
  );

  // Flags are decoded from the counters' next values and registered on the
  // same edge, so they line up with hcounter/vcounter with no lag.
  // NOTE: every field gets a default before the conditional logic so that no
  // path leaves a value held, which would infer a latch.
  always_comb begin
    sync_d       = SYNC_RST;
    sync_d.hs    = in_window(h_next, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    sync_d.vs    = in_window(v_next, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
    sync_d.blank = (h_next >= H_VIS_C) || (v_next >= V_VIS_C);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign hcounter = h_count;
  assign vcounter = v_count;
  assign HS       = sync_q.hs;
  assign VS       = sync_q.vs;
  assign blank    = sync_q.blank;

endmodule

// File: tb/tb_vga_controller_640_60.sv
// -----------------------------------------------------------------------------
// tb_vga_controller_640_60
// Two instances share clock and reset: one with the standard 640x480 timing
// (line-level behaviour) and one with a shrunken raster of 32 x 21 so that
// whole frames, vertical sync and frame wrap are reachable in a short run.
// Small raster: H 16/4/6/6 (HS on columns 20..25), V 12/3/2/4 (VS on lines
// 15..16), frame = 672 cycles.
// Expected vectors are queued with the cycle (edges since reset release) at
// which they apply; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_vga_controller_640_60;

  typedef struct {
    int    cyc;
    int    h;
    int    v;
    int    hs;
    int    vs;
    int    blank;
    string name;
  } vec_t;

  localparam int S_FRAME = 672;
  localparam int RUN_CYC = 2922;

  logic        clk;
  logic        rst;
  logic        hs_f, vs_f, blank_f;
  logic [10:0] h_f, v_f;
  logic        hs_s, vs_s, blank_s;
  logic [10:0] h_s, v_s;

  int total;
  int bad;
  int cyc;

  vec_t qf[$];
  vec_t qs[$];

  // Measurements collected by the monitor, cleared while reset is held.
  int f_line_starts[$];
  int f_frame_starts;
  int f_hs_low0;
  int f_blank0;
  int s_frame_starts[$];
  int s_vs_low[2];
  int s_hs_low[2];
  int s_blank[2];

  vga_controller_640_60 dut_full (
    .pixel_clk (clk),
    .rst       (rst),
    .HS        (hs_f),
    .VS        (vs_f),
    .hcounter  (h_f),
    .vcounter  (v_f),
    .blank     (blank_f)
  );

  vga_controller_640_60 #(
    .H_VISIBLE (16),
    .H_FP      (4),
    .H_SYNC    (6),
    .H_BP      (6),
    .V_VISIBLE (12),
    .V_FP      (3),
    .V_SYNC    (2),
    .V_BP      (4),
    .SYNC_POL  (1'b0)
  ) dut_small (
    .pixel_clk (clk),
    .rst       (rst),
    .HS        (hs_s),
    .VS        (vs_s),
    .hcounter  (h_s),
    .vcounter  (v_s),
    .blank     (blank_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_vec(input vec_t e, input int now, input logic [10:0] h,
                             input logic [10:0] v, input logic hs, input logic vs,
                             input logic bl);
    if (e.cyc != now) check({e.name, ".cycle"}, now, e.cyc);
    check({e.name, ".h"}, int'(h), e.h);
    check({e.name, ".v"}, int'(v), e.v);
    check({e.name, ".hs"}, int'(hs), e.hs);
    check({e.name, ".vs"}, int'(vs), e.vs);
    check({e.name, ".blank"}, int'(bl), e.blank);
  endtask

  // Monitor: scoreboard pops plus running measurements.
  always @(negedge clk) begin
    if (rst) begin
      f_line_starts.delete();
      s_frame_starts.delete();
      f_frame_starts = 0;
      f_hs_low0      = 0;
      f_blank0       = 0;
      for (int i = 0; i < 2; i++) begin
        s_vs_low[i] = 0;
        s_hs_low[i] = 0;
        s_blank[i]  = 0;
      end
    end else begin
      while (qf.size() > 0 && qf[0].cyc <= cyc) begin
        compare_vec(qf.pop_front(), cyc, h_f, v_f, hs_f, vs_f, blank_f);
      end
      while (qs.size() > 0 && qs[0].cyc <= cyc) begin
        compare_vec(qs.pop_front(), cyc, h_s, v_s, hs_s, vs_s, blank_s);
      end
      if (h_f == 11'd0) f_line_starts.push_back(cyc);
      if (h_f == 11'd0 && v_f == 11'd0) f_frame_starts++;
      if (cyc < 800) begin
        if (!hs_f)   f_hs_low0++;
        if (blank_f) f_blank0++;
      end
      if (h_s == 11'd0 && v_s == 11'd0) s_frame_starts.push_back(cyc);
      if (cyc < 2 * S_FRAME) begin
        if (!vs_s)   s_vs_low[cyc / S_FRAME]++;
        if (!hs_s)   s_hs_low[cyc / S_FRAME]++;
        if (blank_s) s_blank[cyc / S_FRAME]++;
      end
    end
  end

  task automatic push_f(input int c, input int h, input int v, input int hs,
                        input int vs, input int bl, input string name);
    vec_t e;
    e = '{cyc: c, h: h, v: v, hs: hs, vs: vs, blank: bl, name: name};
    qf.push_back(e);
  endtask

  task automatic push_s(input int c, input int h, input int v, input int hs,
                        input int vs, input int bl, input string name);
    vec_t e;
    e = '{cyc: c, h: h, v: v, hs: hs, vs: vs, blank: bl, name: name};
    qs.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".f_h"}, int'(h_f), 0);
    check({tag, ".f_v"}, int'(v_f), 0);
    check({tag, ".f_hs"}, int'(hs_f), 1);
    check({tag, ".f_vs"}, int'(vs_f), 1);
    check({tag, ".f_blank"}, int'(blank_f), 0);
    check({tag, ".s_h"}, int'(h_s), 0);
    check({tag, ".s_v"}, int'(v_s), 0);
    check({tag, ".s_hs"}, int'(hs_s), 1);
    check({tag, ".s_vs"}, int'(vs_s), 1);
    check({tag, ".s_blank"}, int'(blank_s), 0);
  endtask

  // One run from reset release to a mid-frame asynchronous reset.
  task automatic run_phase(input string tag);
    // Full-size raster, line level.
    push_f(1,    1,   0, 1, 1, 0, {tag, "_f_first_edge"});
    push_f(639,  639, 0, 1, 1, 0, {tag, "_f_last_visible"});
    push_f(640,  640, 0, 1, 1, 1, {tag, "_f_blank_rise"});
    push_f(655,  655, 0, 1, 1, 1, {tag, "_f_hs_before"});
    push_f(656,  656, 0, 0, 1, 1, {tag, "_f_hs_first"});
    push_f(751,  751, 0, 0, 1, 1, {tag, "_f_hs_last"});
    push_f(752,  752, 0, 1, 1, 1, {tag, "_f_hs_after"});
    push_f(799,  799, 0, 1, 1, 1, {tag, "_f_line_end"});
    push_f(800,  0,   1, 1, 1, 0, {tag, "_f_line_wrap"});
    push_f(2256, 656, 2, 0, 1, 1, {tag, "_f_line2_hs"});
    push_f(2922, 522, 3, 1, 1, 0, {tag, "_f_mid"});
    // Shrunken raster, frame level.
    push_s(19,   19, 0,  1, 1, 1, {tag, "_s_hs_before"});
    push_s(20,   20, 0,  0, 1, 1, {tag, "_s_hs_first"});
    push_s(25,   25, 0,  0, 1, 1, {tag, "_s_hs_last"});
    push_s(26,   26, 0,  1, 1, 1, {tag, "_s_hs_after"});
    push_s(367,  15, 11, 1, 1, 0, {tag, "_s_last_line_visible"});
    push_s(368,  16, 11, 1, 1, 1, {tag, "_s_last_line_blank"});
    push_s(384,  0,  12, 1, 1, 1, {tag, "_s_vblank_start"});
    push_s(479,  31, 14, 1, 1, 1, {tag, "_s_vs_before"});
    push_s(480,  0,  15, 1, 0, 1, {tag, "_s_vs_first"});
    push_s(543,  31, 16, 1, 0, 1, {tag, "_s_vs_last"});
    push_s(544,  0,  17, 1, 1, 1, {tag, "_s_vs_after"});
    push_s(671,  31, 20, 1, 1, 1, {tag, "_s_frame_end"});
    push_s(672,  0,  0,  1, 1, 0, {tag, "_s_frame_wrap"});
    push_s(704,  0,  1,  1, 1, 0, {tag, "_s_frame2_line1"});
    push_s(2922, 10, 7,  1, 1, 0, {tag, "_s_mid"});

    @(negedge clk);
    rst = 1'b0;
    repeat (RUN_CYC) @(negedge clk);
    #1;

    check({tag, "_f_queue_left"}, qf.size(), 0);
    check({tag, "_s_queue_left"}, qs.size(), 0);
    qf.delete();
    qs.delete();

    check({tag, "_f_hs_low_line0"}, f_hs_low0, 96);
    check({tag, "_f_blank_line0"}, f_blank0, 160);
    check({tag, "_f_frame_starts"}, f_frame_starts, 1);
    check({tag, "_f_line_starts"}, f_line_starts.size(), 4);
    for (int i = 1; i < f_line_starts.size(); i++)
      check({tag, "_f_line_period"}, f_line_starts[i] - f_line_starts[i-1], 800);

    check({tag, "_s_frame_starts"}, s_frame_starts.size(), 5);
    for (int i = 1; i < s_frame_starts.size(); i++)
      check({tag, "_s_frame_period"}, s_frame_starts[i] - s_frame_starts[i-1], S_FRAME);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_s_vs_low_cycles"}, s_vs_low[i], 64);
      check({tag, "_s_hs_low_cycles"}, s_hs_low[i], 126);
      check({tag, "_s_blank_cycles"}, s_blank[i], 480);
    end

    // Asynchronous reset mid-line / mid-frame, away from any clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset({tag, "_async_rst"});
    repeat (3) @(posedge clk);
    #1;
    check_reset({tag, "_rst_held"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    #23;
    check_reset("por");
    run_phase("p1");
    run_phase("p2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
